// File: rtl/cordic_host_pkg.sv
// Shared types and sizing helpers for the CORDIC byte-serial host initiator.
package cordic_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Request bytes: X then Y, each WIDTH bits.
  function automatic int ntx(input int width);
    return (2 * width) / 8;
  endfunction

  // Response bytes: magnitude then phase.
  function automatic int nrx(input int width, input int phase_w);
    return (width + phase_w) / 8;
  endfunction

endpackage

// File: rtl/cordic_host_watchdog.sv
// Stall watchdog for the byte host; only built when CORDIC_HOST_TIMEOUT_EN is defined.
module cordic_host_watchdog
  import cordic_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires during the cycle whose closing edge would be the TIMEOUT_CYCLES-th idle one.
  assign o_expired = i_count && !i_clear && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cordic_byte_host.sv
// Byte-serial host for the CORDIC wrapper: serializes (X, Y), collects (mag, phase).
// Optional stall watchdog enabled by defining CORDIC_HOST_TIMEOUT_EN.
module cordic_byte_host
  import cordic_host_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int PHASE_W        = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   mag_out,
  output logic [PHASE_W-1:0] phase_out,
  output logic               resp_err,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready
);

  localparam int NTX   = ntx(WIDTH);
  localparam int NRX   = nrx(WIDTH, PHASE_W);
  localparam int RXW   = WIDTH + PHASE_W;
  localparam int IDX_W = $clog2((NTX > NRX) ? NTX : NRX);
  localparam logic [IDX_W-1:0] TX_LAST = IDX_W'(NTX - 1);
  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(NRX - 1);

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [2*WIDTH-1:0] r_sr;
  logic [RXW-1:0]     r_rx;

  logic w_tx_hs;
  logic w_rx_hs;
  logic w_busy;
  logic w_expired;

  assign w_busy  = (r_state == TX) || (r_state == RX);
  assign w_tx_hs = (r_state == TX) && tx_ready;
  assign w_rx_hs = (r_state == RX) && rx_valid;

  // Every output is a decode of registered state; nothing flows straight from an input.
  assign req_ready  = (r_state == IDLE);
  assign tx_valid   = (r_state == TX);
  assign rx_ready   = (r_state == RX);
  assign resp_valid = (r_state == DONE);
  assign tx_data    = r_sr[7:0];
  assign mag_out    = r_rx[WIDTH-1:0];
  assign phase_out  = r_rx[RXW-1:WIDTH];

`ifdef CORDIC_HOST_TIMEOUT_EN
  logic r_err;

  cordic_host_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_busy || w_tx_hs || w_rx_hs),
    .i_count  (w_busy),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && req_valid) begin
      r_err <= 1'b0;
    end else if (w_expired) begin
      r_err <= 1'b1;
    end
  end

  assign resp_err = r_err;
`else
  // Watchdog compiled out: the expression is constant 0 for any legal TIMEOUT_CYCLES.
  assign w_expired = (TIMEOUT_CYCLES < 0);
  assign resp_err  = 1'b0;
`endif

  // NOTE: state is written only with <= so every branch sees pre-edge values; the
  // response buffer is reset too because mag_out/phase_out must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_sr    <= '0;
      r_rx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_sr    <= {y_in, x_in};
            r_rx    <= '0;
            r_idx   <= '0;
            r_state <= TX;
          end
        end
        TX: begin
          if (w_tx_hs) begin
            r_sr <= r_sr >> 8;
            if (r_idx == TX_LAST) begin
              r_idx   <= '0;
              r_state <= RX;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (w_expired) begin
            r_idx   <= '0;
            r_state <= DONE;
          end
        end
        RX: begin
          if (w_rx_hs) begin
            for (int i = 0; i < NRX; i++) begin
              if (r_idx == IDX_W'(i)) r_rx[i*8 +: 8] <= rx_data;
            end
            if (r_idx == RX_LAST) begin
              r_idx   <= '0;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (w_expired) begin
            r_idx   <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_byte_host.sv
// Directed bench for cordic_byte_host acting as its own wrapper model.
module tb_cordic_byte_host;

  localparam int WIDTH   = 16;
  localparam int PHASE_W = 32;
  localparam int NTX     = 4;
  localparam int NRX     = 6;
  localparam int TO      = 16;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   x_in;
  logic [WIDTH-1:0]   y_in;
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   mag_out;
  logic [PHASE_W-1:0] phase_out;
  logic               resp_err;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;

  cordic_byte_host #(
    .WIDTH         (WIDTH),
    .PHASE_W       (PHASE_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .mag_out   (mag_out),
    .phase_out (phase_out),
    .resp_err  (resp_err),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] txb;   // expected wire bytes, first byte in [7:0]
    logic [15:0] mag;
    logic [31:0] ph;
  } vec_t;

  vec_t vecs[4];

  // Wrapper-model knobs
  int          tx_stall_at  = -1;
  int          tx_stall_len = 0;
  int          rx_gap       = 0;
  int          resp_hold    = 0;
  logic        keep_req     = 1'b0;
  logic [15:0] next_x       = '0;
  logic [15:0] next_y       = '0;

  task automatic send_req(input logic [15:0] x, input logic [15:0] y, output int acc);
    int n;
    n = 0;
    req_valid = 1'b1;
    x_in = x;
    y_in = y;
    while (!req_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready before accept", req_ready, 1'b1);
    @(posedge clk); #1;
    acc = cyc;
    if (keep_req) begin
      x_in = next_x;
      y_in = next_y;
    end else begin
      req_valid = 1'b0;
    end
    check("tx_valid after accept", tx_valid, 1'b1);
  endtask

  task automatic tx_phase(input logic [31:0] exp_bytes);
    for (int k = 0; k < NTX; k++) begin
      if (k == tx_stall_at) begin
        tx_ready = 1'b0;
        for (int s = 0; s < tx_stall_len; s++) begin
          check("tx_valid held in stall", tx_valid, 1'b1);
          check("tx_data held in stall", tx_data, exp_bytes[k*8 +: 8]);
          @(posedge clk); #1;
        end
      end
      tx_ready = 1'b1;
      check("tx_valid", tx_valid, 1'b1);
      check("tx_data byte", tx_data, exp_bytes[k*8 +: 8]);
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
  endtask

  task automatic rx_phase(input logic [47:0] resp, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      if (k > 0) begin
        for (int g = 0; g < rx_gap; g++) begin
          rx_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      rx_valid = 1'b1;
      rx_data  = resp[k*8 +: 8];
      check("rx_ready", rx_ready, 1'b1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic resp_phase(input logic [15:0] mag, input logic [31:0] ph,
                            input logic err, output int hs);
    check("resp_valid", resp_valid, 1'b1);
    check("mag_out", mag_out, mag);
    check("phase_out", phase_out, ph);
    check("resp_err", resp_err, err);
    for (int h = 0; h < resp_hold; h++) begin
      resp_ready = 1'b0;
      @(posedge clk); #1;
      check("resp_valid held", resp_valid, 1'b1);
      check("mag_out held", mag_out, mag);
      check("phase_out held", phase_out, ph);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    resp_ready = 1'b0;
    check("resp_valid after handshake", resp_valid, 1'b0);
    check("req_ready after handshake", req_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, req_ready, 1'b1);
    check({tag, " tx_valid"}, tx_valid, 1'b0);
    check({tag, " tx_data"}, tx_data, 8'h00);
    check({tag, " rx_ready"}, rx_ready, 1'b0);
    check({tag, " resp_valid"}, resp_valid, 1'b0);
    check({tag, " resp_err"}, resp_err, 1'b0);
    check({tag, " mag_out"}, mag_out, 16'h0000);
    check({tag, " phase_out"}, phase_out, 32'h0000_0000);
  endtask

  initial begin
    int acc;
    int acc2;
    int hs;

    vecs[0] = '{x: 16'd12000, y: 16'd8000,  txb: 32'h1F40_2EE0, mag: 16'h3456, ph: 32'h0012_ABCD};
    vecs[1] = '{x: 16'hC568,  y: 16'd10000, txb: 32'h2710_C568, mag: 16'h4A1B, ph: 32'hFFFF_8000};
    vecs[2] = '{x: 16'h8000,  y: 16'h7FFF,  txb: 32'h7FFF_8000, mag: 16'hFFFF, ph: 32'h8000_0001};
    vecs[3] = '{x: 16'h0000,  y: 16'h0000,  txb: 32'h0000_0000, mag: 16'h0000, ph: 32'h0000_0000};

    rst_n = 1'b0; req_valid = 1'b0; x_in = '0; y_in = '0; resp_ready = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait table: bytes, response and 12-cycle latency
    for (int v = 0; v < 4; v++) begin
      send_req(vecs[v].x, vecs[v].y, acc);
      tx_phase(vecs[v].txb);
      rx_phase({vecs[v].ph, vecs[v].mag}, NRX);
      resp_phase(vecs[v].mag, vecs[v].ph, 1'b0, hs);
      check("zero-wait latency", hs - acc + 1, 12);
    end

    // Backpressure on every channel
    tx_stall_at = 1; tx_stall_len = 5; rx_gap = 3; resp_hold = 4;
    send_req(vecs[1].x, vecs[1].y, acc);
    tx_phase(vecs[1].txb);
    rx_phase({vecs[1].ph, vecs[1].mag}, NRX);
    resp_phase(vecs[1].mag, vecs[1].ph, 1'b0, hs);
    tx_stall_at = -1; tx_stall_len = 0; rx_gap = 0; resp_hold = 0;

    // Asynchronous reset after three result bytes, then a clean request
    send_req(vecs[0].x, vecs[0].y, acc);
    tx_phase(vecs[0].txb);
    rx_phase({vecs[0].ph, vecs[0].mag}, 3);
    check("mag partially captured", mag_out, vecs[0].mag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-rx reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(vecs[2].x, vecs[2].y, acc);
    tx_phase(vecs[2].txb);
    rx_phase({vecs[2].ph, vecs[2].mag}, NRX);
    resp_phase(vecs[2].mag, vecs[2].ph, 1'b0, hs);

    // Back-to-back: req_valid stays high, operands change while busy
    keep_req = 1'b1; next_x = vecs[1].x; next_y = vecs[1].y;
    send_req(vecs[0].x, vecs[0].y, acc);
    tx_phase(vecs[0].txb);
    rx_phase({vecs[0].ph, vecs[0].mag}, NRX);
    resp_phase(vecs[0].mag, vecs[0].ph, 1'b0, hs);
    keep_req = 1'b0;
    send_req(vecs[1].x, vecs[1].y, acc2);
    check("back-to-back accept cycle", acc2, hs + 1);
    tx_phase(vecs[1].txb);
    rx_phase({vecs[1].ph, vecs[1].mag}, NRX);
    resp_phase(vecs[1].mag, vecs[1].ph, 1'b0, hs);

`ifdef CORDIC_HOST_TIMEOUT_EN
    // Model goes silent after two result bytes
    send_req(vecs[0].x, vecs[0].y, acc);
    tx_phase(vecs[0].txb);
    rx_phase({vecs[0].ph, vecs[0].mag}, 2);
    for (int i = 1; i <= TO; i++) begin
      @(posedge clk); #1;
      if (i == TO - 1) check("timeout not early", resp_valid, 1'b0);
      if (i == TO) begin
        check("timeout resp_valid", resp_valid, 1'b1);
        check("timeout resp_err", resp_err, 1'b1);
      end
    end
    resp_phase(vecs[0].mag, 32'h0000_0000, 1'b1, hs);
    send_req(vecs[3].x, vecs[3].y, acc);
    check("resp_err cleared on accept", resp_err, 1'b0);
    tx_phase(vecs[3].txb);
    rx_phase({vecs[3].ph, vecs[3].mag}, NRX);
    resp_phase(vecs[3].mag, vecs[3].ph, 1'b0, hs);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
